button_conditioner: RTL

Conditions the raw Nexys push-buttons (BtnC, BtnU, BtnD, BtnL, BtnR) into clean, clock-domain-safe control strobes. It sits directly upstream of the maze game logic: the top level feeds it raw pad levels, and the game logic consumes its one-cycle press pulses, debounced levels and prioritised move requests. Each button gets a metastability synchroniser, a debounce state machine and a hold-to-repeat generator.

---
 rtl/maze_pkg.sv | 25 ++
 rtl/btn_channel.sv | 119 +++++++++++
 rtl/button_conditioner.sv | 54 +++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared constants and types for the maze game input path.
// Button indices, default timing and the per-button debounce FSM state encoding.
package maze_pkg;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_D = 2;
    localparam int unsigned BTN_L = 3;
    localparam int unsigned BTN_R = 4;

    localparam int unsigned DEF_NUM_BTN         = 5;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 15_000_000;
    localparam logic [4:0]  DEF_REPEAT_MASK     = 5'b11110;

    // Bit 1 set means the debounced level is high.
    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StDbPress   = 2'b01,
        StHeld      = 2'b10,
        StDbRelease = 2'b11
    } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, debounce FSM and optional hold-to-repeat counter.
// Press, release and repeat strobes are registered one-cycle pulses.
module btn_channel
    import maze_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RptW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
    localparam logic [RptW-1:0] RptMax = RptW'(REPEAT_DELAY);
    // A period longer than the delay degenerates to a period equal to the delay.
    localparam logic [RptW-1:0] RptReload =
        (REPEAT_PERIOD >= REPEAT_DELAY) ? '0 : RptW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [1:0]      sync_d, sync_q;
    btn_state_e      state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic [RptW-1:0] rpt_d, rpt_q;
    logic            press_d, press_q;
    logic            release_d, release_q;
    logic            s;

    assign sync_d = {sync_q[0], btn_raw_i};
    assign s      = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s) begin
                    state_d = StDbPress;
                    cnt_d   = CntW'(1);
                end
            end
            StDbPress: begin
                if (!s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                    rpt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                if (!s) begin
                    state_d = StDbRelease;
                    cnt_d   = CntW'(1);
                end else if (REPEAT_EN) begin
                    if (rpt_q == RptMax - RptW'(1)) begin
                        rpt_d   = RptReload;
                        press_d = 1'b1;
                    end else if (rpt_q < RptMax) begin
                        rpt_d = rpt_q + RptW'(1);
                    end
                end
            end
            StDbRelease: begin
                // The repeat counter is left untouched here so a bounce only pauses it.
                if (s) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            rpt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level_o   = (state_q == StHeld) || (state_q == StDbRelease);
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw push-buttons into debounced levels, press/release/repeat pulses
// and a single prioritised move strobe for the maze game logic.
module button_conditioner
    import maze_pkg::*;
#(
    parameter int unsigned       NUM_BTN         = DEF_NUM_BTN,
    parameter int unsigned       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned       REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned       REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK    = NUM_BTN'(DEF_REPEAT_MASK)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [3:0]         move_req,
    output logic               any_press
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_chan (
            .clk_i        (clk),
            .rst_ni       (reset),
            .btn_raw_i    (btn_raw[i]),
            .btn_level_o  (btn_level[i]),
            .btn_press_o  (btn_press[i]),
            .btn_release_o(btn_release[i])
        );
    end

    // Only one move per cycle reaches the game; U > D > L > R.
    always_comb begin
        move_req = 4'b0000;
        if (btn_press[BTN_U]) begin
            move_req = 4'b0001;
        end else if (btn_press[BTN_D]) begin
            move_req = 4'b0010;
        end else if (btn_press[BTN_L]) begin
            move_req = 4'b0100;
        end else if (btn_press[BTN_R]) begin
            move_req = 4'b1000;
        end
    end

    assign any_press = |btn_press;

endmodule
